// File: rtl/jtframe_sdram_arb_if.sv
// Signal bundle between the game-side ROM requesters, the SDRAM controller
// and the arbiter. "master" is the arbiter's view; "slave" is the other side
// (game core plus SDRAM controller).
interface jtframe_sdram_arb_if #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
);
  logic                downloading;
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                sdram_req;
  logic                sdram_ack;
  logic [AW-1:0]       sdram_addr;
  logic [DW-1:0]       data_read;
  logic                data_rdy;
  logic                loop_rst;
  logic                refresh_en;
  logic                busy;

  modport master (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_read, data_rdy, loop_rst,
    output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en, busy
  );

  modport slave (
    output downloading, slot_cs, slot_addr, sdram_ack, data_read, data_rdy, loop_rst,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en, busy
  );
endinterface

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters.
// Every slot keeps a one-word cache; hits answer combinationally, misses are
// queued and served one SDRAM transaction at a time.
module jtframe_sdram_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic clk_rom,
  input  logic rst,
  jtframe_sdram_arb_if.master bus
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  sel_q, sel_d;
  logic [IW-1:0]  last_q, last_d;
  logic           req_q, req_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  cache_addr_q [SLOTS];
  logic [AW-1:0]  cache_addr_d [SLOTS];
  logic [DW-1:0]  cache_data_q [SLOTS];
  logic [DW-1:0]  cache_data_d [SLOTS];
  logic [SLOTS-1:0] valid_q, valid_d;

  logic [SLOTS-1:0] hit, pend;
  logic             grant_found;
  logic [IW-1:0]    grant_idx, scan_idx;
  logic             fill;

  // Cache lookup: a hit needs a live request whose address matches the stored word
  always_comb begin
    hit  = '0;
    pend = '0;
    for (int i = 0; i < SLOTS; i++) begin
      hit[i]  = bus.slot_cs[i] & valid_q[i] & (bus.slot_addr[i*AW +: AW] == cache_addr_q[i]);
      pend[i] = bus.slot_cs[i] & ~hit[i];
    end
  end

  // Round-robin pick: first pending slot after the one served last
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      scan_idx = IW'((int'(last_q) + k) % SLOTS);
      if (!grant_found && pend[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Transaction FSM next state plus cache fill; loop_rst/downloading abort and flush
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    req_d        = req_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    fill         = 1'b0;
    if (bus.loop_rst || bus.downloading) begin
      valid_d = '0;
      req_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            sel_d   = grant_idx;
            addr_d  = bus.slot_addr[int'(grant_idx)*AW +: AW];
            req_d   = 1'b1;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.sdram_ack) begin
            req_d = 1'b0;
            if (bus.data_rdy) begin
              fill    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (bus.data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (fill) begin
        cache_data_d[sel_q] = bus.data_read;
        cache_addr_d[sel_q] = addr_q;
        valid_d[sel_q]      = 1'b1;
        last_d              = sel_q;
      end
    end
  end

  // State and cache registers
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= IW'(SLOTS - 1);
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        cache_addr_q[i] <= '0;
        cache_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
    end
  end

  // Cached words are always visible on the slot data buses
  always_comb begin
    bus.slot_dout = '0;
    for (int i = 0; i < SLOTS; i++) begin
      bus.slot_dout[i*DW +: DW] = cache_data_q[i];
    end
  end

  assign bus.slot_ok    = hit;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.refresh_en = (state_q == IDLE) & ~|pend;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_jtframe_sdram_arb;
  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic clk_rom = 1'b0;
  logic rst;

  always #5 clk_rom = ~clk_rom;

  jtframe_sdram_arb_if #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) bus ();

  jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk_rom (clk_rom),
    .rst     (rst),
    .bus     (bus)
  );

  // Reference model: per-slot cached word plus the one transaction in flight
  logic [AW-1:0] m_cache_addr [SLOTS];
  logic [DW-1:0] m_cache_data [SLOTS];
  bit            m_valid      [SLOTS];
  int            m_last;
  int            m_serving;
  bit            m_acked;
  logic [AW-1:0] m_req_addr;

  logic [SLOTS-1:0]    cur_cs;
  logic [SLOTS*AW-1:0] cur_addr;
  logic                cur_dl;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SLOTS-1:0] modelPending(input logic [SLOTS-1:0] cs,
                                                    input logic [SLOTS*AW-1:0] addr);
    logic [SLOTS-1:0] p = '0;
    for (int i = 0; i < SLOTS; i++)
      p[i] = cs[i] && !(m_valid[i] && addr[i*AW +: AW] == m_cache_addr[i]);
    return p;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < SLOTS; i++) begin
      m_cache_addr[i] = '0;
      m_cache_data[i] = '0;
      m_valid[i]      = 1'b0;
    end
    m_last     = SLOTS - 1;
    m_serving  = -1;
    m_acked    = 1'b0;
    m_req_addr = '0;
  endtask

  task automatic modelFill(input logic [DW-1:0] data);
    m_cache_data[m_serving] = data;
    m_cache_addr[m_serving] = m_req_addr;
    m_valid[m_serving]      = 1'b1;
    m_last                  = m_serving;
    m_serving               = -1;
    m_acked                 = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model
  task automatic applyStimulus(input logic [SLOTS-1:0] cs, input logic [SLOTS*AW-1:0] addr,
                               input logic dl, input logic lr, input logic ack,
                               input logic rdy, input logic [DW-1:0] data);
    logic [SLOTS-1:0] p;
    bus.slot_cs     = cs;
    bus.slot_addr   = addr;
    bus.downloading = dl;
    bus.loop_rst    = lr;
    bus.sdram_ack   = ack;
    bus.data_rdy    = rdy;
    bus.data_read   = data;
    @(negedge clk_rom);
    p = modelPending(cs, addr);
    checkOutput("slot_ok", bus.slot_ok, cs & ~p);
    checkOutput("refresh_en", bus.refresh_en, (m_serving < 0) && (p == '0));
    checkOutput("busy", bus.busy, m_serving >= 0);
    checkOutput("sdram_req", bus.sdram_req, (m_serving >= 0) && !m_acked);
    checkOutput("sdram_addr", bus.sdram_addr, m_req_addr);
    for (int i = 0; i < SLOTS; i++)
      checkOutput("slot_dout", bus.slot_dout[i*DW +: DW], m_cache_data[i]);
    if (lr || dl) begin
      for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
      m_serving = -1;
      m_acked   = 1'b0;
    end else if (m_serving < 0) begin
      for (int k = 1; k <= SLOTS; k++) begin
        int s = (m_last + k) % SLOTS;
        if (p[s]) begin
          m_serving  = s;
          m_acked    = 1'b0;
          m_req_addr = addr[s*AW +: AW];
          break;
        end
      end
    end else if (!m_acked) begin
      if (ack && rdy) modelFill(data);
      else if (ack) m_acked = 1'b1;
    end else if (rdy) begin
      modelFill(data);
    end
    @(posedge clk_rom);
    #1;
  endtask

  task automatic tick(input logic ack, input logic rdy, input logic [DW-1:0] data, input logic lr);
    applyStimulus(cur_cs, cur_addr, cur_dl, lr, ack, rdy, data);
  endtask

  task automatic setAddr(input int slot, input logic [AW-1:0] a);
    cur_addr[slot*AW +: AW] = a;
  endtask

  task automatic doReset();
    cur_cs   = '0;
    cur_addr = '0;
    cur_dl   = 1'b0;
    bus.slot_cs = '0; bus.slot_addr = '0; bus.downloading = 1'b0; bus.loop_rst = 1'b0;
    bus.sdram_ack = 1'b0; bus.data_rdy = 1'b0; bus.data_read = '0;
    rst = 1'b1;
    modelReset();
    @(negedge clk_rom);
    checkOutput("rst_slot_ok", bus.slot_ok, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_req", bus.sdram_req, 0);
    checkOutput("rst_addr", bus.sdram_addr, 0);
    checkOutput("rst_refresh_idle", bus.refresh_en, 1);
    bus.slot_cs = 4'b0101;
    #1;
    checkOutput("rst_refresh_cs", bus.refresh_en, 0);
    checkOutput("rst_slot_ok_cs", bus.slot_ok, 0);
    bus.slot_cs = '0;
    @(posedge clk_rom);
    #1;
    rst = 1'b0;
  endtask

  // Serve one miss with fixed controller latencies and check the granted address
  task automatic serveOne(input logic [AW-1:0] exp_addr, input int ack_delay, input int data_delay,
                          input logic [DW-1:0] data, input bit same);
    tick(1'b0, 1'b0, '0, 1'b0);
    checkOutput("grant_addr", bus.sdram_addr, exp_addr);
    checkOutput("grant_req", bus.sdram_req, 1);
    repeat (ack_delay) tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, same, data, 1'b0);
    if (!same) begin
      checkOutput("req_after_ack", bus.sdram_req, 0);
      repeat (data_delay) tick(1'b0, 1'b0, '0, 1'b0);
      tick(1'b0, 1'b1, data, 1'b0);
    end
    checkOutput("idle_after_fill", bus.busy, 0);
  endtask

  // Act as the controller until every request is served, within a cycle budget
  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      logic a = 1'b0;
      logic r = 1'b0;
      if (m_serving >= 0 && !m_acked) a = ($urandom % 2) == 0;
      else if (m_serving >= 0) r = ($urandom % 2) == 0;
      tick(a, r, $urandom, 1'b0);
      if (m_serving < 0 && modelPending(cur_cs, cur_addr) == '0) done = 1'b1;
    end
    checkOutput("drain_done", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dl_left;
    logic lr, a, r;
    rst = 1'b1;
    doReset();

    // Single miss, then the cached word answers
    cur_cs = 4'b0001;
    setAddr(0, 22'h000100);
    serveOne(22'h000100, 2, 3, 32'hDEADBEEF, 1'b0);
    checkOutput("t1_ok", bus.slot_ok[0], 1);
    checkOutput("t1_dout", bus.slot_dout[31:0], 32'hDEADBEEF);
    checkOutput("t1_refresh", bus.refresh_en, 1);

    // Hit held without traffic, then an address change misses immediately
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t2_no_req", bus.sdram_req, 0);
    setAddr(0, 22'h000101);
    bus.slot_addr = cur_addr;
    #1;
    checkOutput("t2_ok_drop", bus.slot_ok[0], 0);
    serveOne(22'h000101, 1, 2, 32'hCAFEF00D, 1'b0);

    // Round robin from a fresh reset
    doReset();
    cur_cs = 4'b1111;
    for (int i = 0; i < SLOTS; i++) setAddr(i, AW'(32'h200 + 32'h100 * i));
    for (int i = 0; i < SLOTS; i++) serveOne(AW'(32'h200 + 32'h100 * i), 1, 1, $urandom, 1'b0);
    setAddr(0, 22'h000210);
    setAddr(2, 22'h000410);
    serveOne(22'h000210, 0, 1, $urandom, 1'b0);
    serveOne(22'h000410, 1, 0, $urandom, 1'b0);

    // Ack and data in the same cycle
    setAddr(1, 22'h000310);
    serveOne(22'h000310, 1, 0, 32'h12345678, 1'b1);
    checkOutput("t4_dout", bus.slot_dout[63:32], 32'h12345678);
    checkOutput("t4_ok", bus.slot_ok[1], 1);

    // loop_rst aborts a transaction waiting for data; a stray data_rdy is ignored
    setAddr(3, 22'h000510);
    tick(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t5_grant", bus.sdram_addr, 22'h000510);
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1);
    checkOutput("t5_req", bus.sdram_req, 0);
    checkOutput("t5_busy", bus.busy, 0);
    checkOutput("t5_ok", bus.slot_ok, 0);
    tick(1'b0, 1'b1, 32'hBAD0BAD0, 1'b0);
    checkOutput("t5_regrant", bus.sdram_addr, 22'h000410);
    drain(200);

    // Downloading blocks all grants and flushes the caches
    doReset();
    cur_cs = 4'b1111;
    for (int i = 0; i < SLOTS; i++) setAddr(i, AW'(32'h700 + i));
    cur_dl = 1'b1;
    repeat (5) tick(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t6_req", bus.sdram_req, 0);
    checkOutput("t6_ok", bus.slot_ok, 0);
    checkOutput("t6_refresh", bus.refresh_en, 0);
    cur_dl = 1'b0;
    serveOne(22'h000700, 1, 1, $urandom, 1'b0);
    drain(200);

    // Randomized traffic with spurious pulses, aborts and download windows
    dl_left = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if ($urandom % 10 == 0) cur_cs[i] = ~cur_cs[i];
        if ($urandom % 12 == 0) setAddr(i, AW'(32'h1000 * (i + 1) + $urandom_range(0, 3)));
      end
      if (dl_left > 0) dl_left--;
      else if ($urandom % 150 == 0) dl_left = $urandom_range(3, 12);
      cur_dl = (dl_left > 0);
      lr = ($urandom % 60 == 0);
      a = 1'b0;
      r = 1'b0;
      if (m_serving >= 0 && !m_acked) begin
        a = ($urandom % 3 == 0);
        r = a ? ($urandom % 4 == 0) : ($urandom % 8 == 0);
      end else if (m_serving >= 0) begin
        r = ($urandom % 3 == 0);
        a = ($urandom % 8 == 0);
      end else begin
        a = ($urandom % 10 == 0);
        r = ($urandom % 10 == 0);
      end
      tick(a, r, $urandom, lr);
    end
    cur_dl = 1'b0;
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Shares the board's single SDRAM read port among SLOTS game-side ROM requesters: main CPU, sound CPU, characters, sprites.
- SDRAM port signals: sdram_req/sdram_ack/sdram_addr/data_read/data_rdy, plus refresh_en.
- Each slot keeps a one-word cache, so repeated reads of the same address complete without an SDRAM access.
- Misses are served in round-robin order, one outstanding SDRAM transaction at a time.
- Sits between the game core and the board SDRAM controller, in the clk_rom domain.

Parameters:
SLOTS, 4, number of requesters (2..8)
AW, 22, word address width, matches sdram_addr
DW, 32, data width, matches data_read

Ports:
clk_rom  in  1  SDRAM-side clock; all logic is clocked on its rising edge
rst  in  1  asynchronous, active-high reset
downloading  in  1  ROM download in progress; arbiter idles and flushes caches
slot_cs  in  SLOTS  per-slot read request, level-sensitive
slot_addr  in  SLOTS*AW  per-slot address; slot i at [i*AW +: AW]
slot_ok  out  SLOTS  slot_dout valid for the current slot_addr
slot_dout  out  SLOTS*DW  per-slot cached data word
sdram_req  out  1  request to the SDRAM controller
sdram_ack  in  1  request accepted (1-cycle pulse)
sdram_addr  out  AW  address of the transaction
data_read  in  DW  SDRAM read data
data_rdy  in  1  data_read valid (1-cycle pulse)
loop_rst  in  1  controller loop reset; aborts any transaction
refresh_en  out  1  high when the arbiter is idle with nothing pending
busy  out  1  high when the FSM is not in IDLE

Behaviour:
Per-slot state:
- Registers: cache_addr[i] (AW), cache_data[i] (DW), valid[i].
- hit[i] = slot_cs[i] & valid[i] & (slot_addr[i] == cache_addr[i]).
- slot_ok[i] = hit[i], combinational: 0-cycle latency on a hit.
- slot_dout[i] = cache_data[i] at all times.
- pend[i] = slot_cs[i] & ~hit[i].

FSM states: IDLE, WAIT_ACK, WAIT_DATA.
- IDLE:
  - If ~downloading & |pend: pick the first pending slot scanning last+1, last+2, ... (mod SLOTS).
  - Register sel, the grant, and sdram_addr <= slot_addr[sel].
  - Set sdram_req <= 1; go to WAIT_ACK.
- WAIT_ACK:
  - Hold sdram_req = 1 and sdram_addr stable.
  - On sdram_ack: sdram_req <= 0; go to WAIT_DATA.
  - If sdram_ack and data_rdy arrive in the same cycle, complete as in WAIT_DATA and go to IDLE.
- WAIT_DATA: on data_rdy:
  - cache_data[sel] <= data_read; cache_addr[sel] <= latched sdram_addr; valid[sel] <= 1.
  - last <= sel; go to IDLE.
  - slot_ok[sel] rises the next cycle if slot_addr[sel] is unchanged.
- Minimum miss latency: grant cycle + ack + data, i.e. 3 cycles plus controller latency.

Address or cs changes mid-transaction:
- If a slot changes slot_addr or drops slot_cs mid-transaction, the fill still completes into its cache.
- The hit compare then fails and a new request is raised.
- No transaction is cancelled except by loop_rst, downloading or rst.

Fairness: a slot is never granted twice in a row while another slot is pending.

loop_rst (synchronous, highest priority after rst), evaluated every cycle:
- Clear all valid[i]; sdram_req <= 0; FSM <= IDLE.
- Keep last; keep cache_data/cache_addr values.

downloading:
- Same clearing as loop_rst while high.
- FSM stays in IDLE; no grants are issued.
- slot_ok is all 0 because valid is cleared.

refresh_en = (state == IDLE) & ~|pend, combinational.

busy = (state != IDLE).

Reset values (rst high, asynchronous):
- state IDLE, sdram_req 0, sdram_addr 0.
- All valid 0, all cache_addr 0, all cache_data 0.
- last = SLOTS-1, so slot 0 wins first.
- Outputs: slot_ok 0, busy 0, refresh_en = ~|slot_cs.

Data-pulse handling:
- sdram_ack or data_rdy seen in IDLE is ignored.
- data_rdy seen in WAIT_ACK without sdram_ack is ignored.

Test Plan:
1. Reset, then slot_cs=0001, slot0 addr 0x000100; controller acks after 2 cycles and gives data_rdy with 0xDEADBEEF 4 cycles later -> sdram_addr=0x000100, sdram_req drops on ack, slot_ok[0]=1 the cycle after data_rdy, slot_dout0=0xDEADBEEF, refresh_en=1 afterwards.
2. Hit: keep slot0 at 0x000100 -> slot_ok[0] held with no new sdram_req. Change to 0x000101 -> slot_ok[0] falls the same cycle and a new request is issued for 0x000101.
3. Round robin: all four slots miss simultaneously, each at a distinct address -> grants in order 0,1,2,3. Re-miss slot0 and slot2 with last=3 -> order 0,2.
4. Simultaneous ack and data_rdy in WAIT_ACK with 0x12345678 -> single transaction completes, FSM back to IDLE, slot filled.
5. loop_rst pulsed in WAIT_DATA -> sdram_req=0, FSM IDLE, all slot_ok=0. A later data_rdy is ignored. Pending slots re-request afterwards.
6. downloading=1 with slot_cs=1111 -> no sdram_req, slot_ok=0, refresh_en=0. After downloading falls -> requests resume from slot 0 after reset.
